data_order_check: RTL and testbench

Per-channel checker for the incrementing count pattern emitted by the upstream count-pattern stage when its send-count mode is active. Sits directly downstream of that stage on the ADC data path. Passes ADC data, enable and valid through unchanged. Tracks each enabled channel's sequence and reports lock status, mismatch pulses and saturating per-channel error counts for bring-up and DMA-ordering validation.

---
 rtl/data_order_check.sv | 139 +++++++++++++
 tb/tb_data_order_check.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_order_check.sv
// Per-channel checker for the upstream incrementing count pattern.
// Passes ADC signals through and reports lock, mismatch and error counts.
module data_order_check #(
    parameter int NUM_CHANNELS   = 4,
    parameter int CHANNEL_WIDTH  = 16,
    parameter int CHANNEL_OFFSET = 1024,
    parameter int ERR_CNT_WIDTH  = 32,
    parameter int RESYNC_ERRORS  = 4
) (
    input  logic                                    adc_clk,
    input  logic                                    adc_rstn,
    input  logic                                    check_enable,
    input  logic                                    strict_start,
    input  logic                                    clear,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   adc_data_in,
    input  logic [NUM_CHANNELS-1:0]                 adc_enable_in,
    input  logic [NUM_CHANNELS-1:0]                 adc_valid_in,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   adc_data_out,
    output logic [NUM_CHANNELS-1:0]                 adc_enable_out,
    output logic [NUM_CHANNELS-1:0]                 adc_valid_out,
    output logic [NUM_CHANNELS-1:0]                 locked,
    output logic [NUM_CHANNELS-1:0]                 mismatch,
    output logic [NUM_CHANNELS-1:0]                 error_sticky,
    output logic [NUM_CHANNELS*ERR_CNT_WIDTH-1:0]   error_count
);

    localparam int CW = CHANNEL_WIDTH;
    localparam int EW = ERR_CNT_WIDTH;
    localparam logic [EW-1:0] CNT_MAX = '1;
    localparam logic [7:0] RESYNC = 8'(RESYNC_ERRORS);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } state_t;

    assign adc_data_out   = adc_data_in;
    assign adc_enable_out = adc_enable_in;
    assign adc_valid_out  = adc_valid_in;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        localparam logic [CW-1:0] BASE = CW'(CHANNEL_OFFSET * i);

        state_t          state, state_nxt;
        logic [CW-1:0]   expected, expected_nxt;
        logic [7:0]      consec, consec_nxt;
        logic [EW-1:0]   count, count_nxt;
        logic            sticky, sticky_nxt;
        logic            mis;
        logic            err;
        logic            chan_on;
        logic            accept;
        logic [CW-1:0]   sample;

        assign sample  = adc_data_in[CW*i +: CW];
        assign chan_on = check_enable & adc_enable_in[i];
        assign accept  = chan_on & adc_valid_in[i];

        always_comb begin
            state_nxt    = state;
            expected_nxt = expected;
            consec_nxt   = consec;
            err          = 1'b0;
            unique case (state)
                IDLE: begin
                    if (chan_on) state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
                    if (accept) begin
                        expected_nxt = sample + 1'b1;
                        consec_nxt   = '0;
                        state_nxt    = TRACK;
                        err          = strict_start && (sample != BASE);
                    end
                end
                TRACK: begin
                    if (accept) begin
                        if (sample == expected) begin
                            expected_nxt = expected + 1'b1;
                            consec_nxt   = '0;
                        end else begin
                            err          = 1'b1;
                            expected_nxt = sample + 1'b1;
                            if (consec + 8'd1 == RESYNC) begin
                                state_nxt  = ACQUIRE;
                                consec_nxt = '0;
                            end else begin
                                consec_nxt = consec + 8'd1;
                            end
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
            // Losing enable always wins and drops tracking back to IDLE
            if (!chan_on) begin
                state_nxt  = IDLE;
                consec_nxt = '0;
            end
        end

        always_comb begin
            count_nxt  = count;
            sticky_nxt = sticky;
            if (clear) begin
                count_nxt  = '0;
                sticky_nxt = 1'b0;
            end else if (err) begin
                sticky_nxt = 1'b1;
                if (count != CNT_MAX) count_nxt = count + 1'b1;
            end
        end

        always_ff @(posedge adc_clk or negedge adc_rstn) begin
            if (!adc_rstn) begin
                state    <= IDLE;
                expected <= '0;
                consec   <= '0;
                count    <= '0;
                sticky   <= 1'b0;
                mis      <= 1'b0;
            end else begin
                state    <= state_nxt;
                expected <= expected_nxt;
                consec   <= consec_nxt;
                count    <= count_nxt;
                sticky   <= sticky_nxt;
                mis      <= err;
            end
        end

        assign locked[i]             = (state == TRACK);
        assign mismatch[i]           = mis;
        assign error_sticky[i]       = sticky;
        assign error_count[EW*i +: EW] = count;
    end

endmodule

// File: tb/tb_data_order_check.sv
// Bench for data_order_check: directed scenarios plus random traffic,
// checked against a rule-level model of each channel.
module tb_data_order_check;

    localparam int NC = 4;
    localparam int CW = 16;
    localparam int RS = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            ce = 1'b0;
    logic            strict = 1'b0;
    logic            clr = 1'b0;
    logic [NC*CW-1:0] din = '0;
    logic [NC-1:0]   en = '0;
    logic [NC-1:0]   vld = '0;

    logic [NC*CW-1:0] dout_a, dout_b;
    logic [NC-1:0]   eno_a, eno_b, vo_a, vo_b;
    logic [NC-1:0]   lk_a, lk_b, mm_a, mm_b, st_a, st_b;
    logic [NC*32-1:0] cnt_a;
    logic [NC*2-1:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_order_check #(.ERR_CNT_WIDTH(32)) dut_a (
        .adc_clk(clk), .adc_rstn(rstn), .check_enable(ce),
        .strict_start(strict), .clear(clr), .adc_data_in(din),
        .adc_enable_in(en), .adc_valid_in(vld), .adc_data_out(dout_a),
        .adc_enable_out(eno_a), .adc_valid_out(vo_a), .locked(lk_a),
        .mismatch(mm_a), .error_sticky(st_a), .error_count(cnt_a)
    );

    data_order_check #(.ERR_CNT_WIDTH(2)) dut_b (
        .adc_clk(clk), .adc_rstn(rstn), .check_enable(ce),
        .strict_start(strict), .clear(clr), .adc_data_in(din),
        .adc_enable_in(en), .adc_valid_in(vld), .adc_data_out(dout_b),
        .adc_enable_out(eno_b), .adc_valid_out(vo_b), .locked(lk_b),
        .mismatch(mm_b), .error_sticky(st_b), .error_count(cnt_b)
    );

    // Reference model: 0 = waiting for enable, 1 = seeding, 2 = tracking
    int          m_mode [NC];
    logic [15:0] m_exp [NC];
    int          m_bad [NC];
    longint      m_cnt [NC];
    bit          m_stk [NC];
    bit          m_mis [NC];

    function automatic logic [15:0] base_of(input int i);
        return 16'((1024 * i) % 65536);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_mode[i] = 0; m_exp[i] = 0; m_bad[i] = 0;
            m_cnt[i] = 0; m_stk[i] = 0; m_mis[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NC; i++) begin
            logic [15:0] d;
            bit e;
            d = din[CW*i +: CW];
            e = 0;
            m_mis[i] = 0;
            if (!ce || !en[i]) begin
                m_mode[i] = 0; m_bad[i] = 0;
            end else if (m_mode[i] == 0) begin
                m_mode[i] = 1;
            end else if (vld[i]) begin
                if (m_mode[i] == 1) begin
                    e = strict && (d != base_of(i));
                    m_exp[i] = d + 16'd1; m_bad[i] = 0; m_mode[i] = 2;
                end else if (d == m_exp[i]) begin
                    m_exp[i] = m_exp[i] + 16'd1; m_bad[i] = 0;
                end else begin
                    e = 1;
                    m_exp[i] = d + 16'd1;
                    m_bad[i] = m_bad[i] + 1;
                    if (m_bad[i] == RS) begin
                        m_mode[i] = 1; m_bad[i] = 0;
                    end
                end
            end
            if (e) m_mis[i] = 1;
            if (clr) begin
                m_cnt[i] = 0; m_stk[i] = 0;
            end else if (e) begin
                m_cnt[i] = m_cnt[i] + 1; m_stk[i] = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic chk_model();
        logic [NC-1:0]    e_lk, e_mm, e_st;
        logic [NC*32-1:0] e_ca;
        logic [NC*2-1:0]  e_cb;
        for (int i = 0; i < NC; i++) begin
            e_lk[i] = (m_mode[i] == 2);
            e_mm[i] = m_mis[i];
            e_st[i] = m_stk[i];
            e_ca[32*i +: 32] = (m_cnt[i] > 64'hFFFFFFFF) ? 32'hFFFFFFFF
                                                        : 32'(m_cnt[i]);
            e_cb[2*i +: 2] = (m_cnt[i] > 3) ? 2'd3 : 2'(m_cnt[i]);
        end
        chk("locked", 128'(lk_a), 128'(e_lk));
        chk("mismatch", 128'(mm_a), 128'(e_mm));
        chk("sticky", 128'(st_a), 128'(e_st));
        chk("count32", 128'(cnt_a), 128'(e_ca));
        chk("count2", 128'(cnt_b), 128'(e_cb));
        chk("locked_b", 128'(lk_b), 128'(e_lk));
    endtask

    task automatic step();
        #1;
        chk("pass_data", 128'(dout_a), 128'(din));
        chk("pass_en_vld", 128'({eno_b, vo_b}), 128'({en, vld}));
        @(posedge clk);
        model_step();
        #1;
        chk_model();
    endtask

    task automatic set_ch(input int i, input logic [15:0] d);
        din[CW*i +: CW] = d;
        vld[i] = 1'b1;
    endtask

    logic [15:0] q [NC][$];
    logic [15:0] prev, r, nx;
    logic [15:0] nxv [NC];

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_status", 128'({lk_a, mm_a, st_a}), 128'(0));
        chk("rst_count", 128'({cnt_a, cnt_b}), 128'(0));
        rstn = 1'b1;
        ce = 1'b1;
        en = '1;
        vld = '0;
        step();

        // Stream, wrap, single glitch and resync scenarios
        for (int v = 16'hFFB8; v <= 16'hFFFF; v++) q[0].push_back(16'(v));
        q[0].push_back(16'h0000);
        q[0].push_back(16'h0001);
        for (int v = 1024; v <= 1100; v++) q[1].push_back(16'(v));
        q[2].push_back(16'd2048); q[2].push_back(16'd2049);
        q[2].push_back(16'd2060); q[2].push_back(16'd2061);
        q[3].push_back(16'd3072);
        prev = 16'd3072;
        for (int k = 0; k < 4; k++) begin
            r = 16'($urandom_range(0, 65535));
            if (r == prev + 16'd1) r = r + 16'd2;
            q[3].push_back(r);
            prev = r;
        end
        q[3].push_back(16'd100); q[3].push_back(16'd101);
        while (q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0) begin
            vld = '0;
            for (int i = 0; i < NC; i++)
                if (q[i].size() > 0) set_ch(i, q[i].pop_front());
            step();
        end
        vld = '0;
        chk("dir_locked", 128'(lk_a), 128'(4'hF));
        chk("dir_count32", 128'(cnt_a), 128'({32'd4, 32'd1, 32'd0, 32'd0}));
        chk("dir_count2", 128'(cnt_b), 128'({2'd3, 2'd1, 2'd0, 2'd0}));
        chk("dir_sticky", 128'(st_a), 128'(4'b1100));

        // Strict start: drop channel 1, re-enable, seed with a wrong value
        strict = 1'b1;
        en[1] = 1'b0;
        step();
        en[1] = 1'b1;
        step();
        set_ch(1, 16'd5);
        step();
        vld = '0;
        chk("strict_cnt1", 128'(cnt_a[63:32]), 128'(32'd1));
        chk("strict_lk1", 128'(lk_a[1]), 128'(1'b1));

        // Clear coinciding with a mismatch on channel 2
        clr = 1'b1;
        set_ch(2, 16'd7);
        step();
        clr = 1'b0;
        vld = '0;
        chk("clr_count", 128'(cnt_a), 128'(0));
        chk("clr_sticky", 128'(st_a), 128'(0));
        chk("clr_mis2", 128'(mm_a[2]), 128'(1'b1));

        // Five non-consecutive errors on channel 0 saturate the 2-bit build
        nx = 16'd2;
        for (int k = 0; k < 5; k++) begin
            set_ch(0, nx + 16'd5);
            step();
            nx = nx + 16'd6;
            set_ch(0, nx);
            step();
            nx = nx + 16'd1;
        end
        vld = '0;
        chk("sat_count2", 128'(cnt_b[1:0]), 128'(2'd3));
        chk("sat_count32", 128'(cnt_a[31:0]), 128'(32'd5));
        chk("sat_lk0", 128'(lk_a[0]), 128'(1'b1));

        // Random traffic with gaps, glitches, enables and clears
        for (int i = 0; i < NC; i++) nxv[i] = 16'($urandom_range(0, 65535));
        for (int c = 0; c < 400; c++) begin
            ce = ($urandom_range(0, 49) != 0);
            clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) strict = ~strict;
            for (int i = 0; i < NC; i++) begin
                en[i] = ($urandom_range(0, 19) != 0);
                vld[i] = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 15))
                    0: r = base_of(i);
                    1, 2: r = 16'($urandom_range(0, 65535));
                    default: r = nxv[i];
                endcase
                din[CW*i +: CW] = r;
                if (vld[i]) nxv[i] = r + 16'd1;
            end
            step();
        end
        clr = 1'b0;

        // Asynchronous reset mid-stream, between clock edges
        ce = 1'b1;
        en = '1;
        for (int i = 0; i < NC; i++) set_ch(i, nxv[i]);
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_status", 128'({lk_a, mm_a, st_a, lk_b, st_b}), 128'(0));
        chk("arst_count", 128'({cnt_a, cnt_b}), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        vld = '0;
        step();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NC; i++) set_ch(i, base_of(i) + 16'(k));
            step();
        end
        chk("post_rst_lk", 128'(lk_a), 128'(4'hF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
